clock_enable_divider_bank: RTL and testbench
============================================

// Module: clock_enable_divider_bank
// PURPOSE
//  Parametrised bank of NUM_CH independent clock-enable generators, all driven from system_clock.
//  Successor to the fixed divide-by-32 touch-screen clock, which produced the 2 MHz touch-screen strobe from 63 MHz.
//  Each channel has its own runtime-loadable divide ratio, an enable, a 1-cycle tick and a ~50% square output.
//  Consumers use tick as a clock enable; no derived clocks are created. New ratios take effect glitch-free at period boundaries.
// PARAMETERS
//  NUM_CH       2   number of independent channels (1..16)
//  DIV_W        8   width of divide ratio
//  DEFAULT_DIV  32  ratio loaded into every channel at reset (63 MHz -> ~2 MHz)
// PORTS
//  system_clock  in   1                   single clock, all logic rising-edge
//  reset_n       in   1                   synchronous, active-low reset
//  ch_enable     in   NUM_CH              per-channel run enable
//  div_load      in   1                   1-cycle request: load div_value into channel div_ch
//  div_ch        in   $clog2(NUM_CH)>=1   target channel of load
//  div_value     in   DIV_W               requested ratio
//  div_ack       out  1                   1-cycle pulse: load accepted
//  div_pending   out  NUM_CH              loaded ratio waiting for period boundary
//  tick          out  NUM_CH              1-cycle enable strobe, once per period
//  square        out  NUM_CH              square wave, period = active ratio
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): count=0, active_div=DEFAULT_DIV, pending=0; tick, square, div_ack, div_pending all 0.
//  - Ratio clamp: any value <2 (0 or 1) is stored as 2. DEFAULT_DIV obeys the same clamp.
//  - Per channel, enabled: count runs 0..active_div-1 and wraps to 0.
//    tick is registered, =1 in the cycle after count==active_div-1 is sampled.
//    Ratio D gives exactly one tick per D cycles.
//  - First tick after enable rises (or reset releases with enable=1): D cycles after the first enabled edge.
//  - square is registered, =1 while count < D/2 (floor), else 0.
//    Odd D: high floor(D/2) cycles, low ceil(D/2) cycles.
//  - Disabled channel: count forced to 0, tick=0, square=0 from the next edge.
//    Re-enable restarts a clean period from count 0.
//  - Load handshake: div_load=1 with div_ch<NUM_CH is always accepted.
//    pending_div[div_ch] <= clamp(div_value); div_pending[div_ch] <= 1; div_ack=1 on the next cycle.
//    div_ch>=NUM_CH: request ignored, no ack, no state change.
//  - Apply: an enabled channel moves pending into active_div on the edge where count wraps to 0.
//    div_pending drops on that same edge. The current period always completes at the old ratio.
//    A disabled channel applies on the next edge.
//  - Load to a channel that already has pending set: overwrites pending (last write wins) and is acked again.
//  - Load coincident with the wrap edge: the old pending (if any) applies now; the new value becomes pending for the following boundary.
//  - Channels never interact. The load port serves one channel per cycle, with no back-pressure.
//  - Reset mid-period or mid-pending: all state discarded, DEFAULT_DIV restored, no tick emitted.
// STRUCTURE
//  - Shared header clk_div_defs.vh: DIV_MIN=2, DEFAULT_TOUCH_DIV=32, SYS_CLK_HZ=63_000_000.
//  - Sub-module clock_enable_channel, one instance per channel (generate loop).
//    Holds count, active_div, pending_div, tick/square registers.
//    Inputs: enable, a load strobe, and a clamped value.
//  - Top level: decodes div_ch, clamps, drives div_ack.
// TESTING
//  1 reset_n=1, ch_enable=2'b11, no loads -> both ticks every 32 cycles, 1 cycle wide; square 16 high / 16 low.
//  2 load ch0 value 5 mid-period (count=10) -> div_ack next cycle, div_pending[0]=1.
//    Remaining 22 cycles stay at 32; then ticks every 5, square 2 high / 3 low; ch1 unchanged.
//  3 load values 0 and 1 -> ratio 2: tick every 2nd cycle, square toggles every cycle.
//  4 two loads (7, then 9) to ch1 within one period -> two acks; only 9 takes effect at the boundary; 7 is never seen.
//  5 drop ch_enable[0] for 3 cycles at count 20 -> tick/square 0; re-enable -> next tick exactly D cycles later.
//  6 div_ch=3 with NUM_CH=2 -> no ack, no pending; then assert reset_n=0 mid-pending -> all outputs 0, ratio back to 32.

Source files
------------

// File: rtl/clock_enable_divider_bank_pkg.sv
// clock_enable_divider_bank_pkg: shared ratio limits and defaults for the divider bank
package clock_enable_divider_bank_pkg;
  localparam int DIV_MIN = 2;
  localparam int DEFAULT_TOUCH_DIV = 32;
  localparam int SYS_CLK_HZ = 63_000_000;
  function automatic int clamp_div(input int v);
    return v < DIV_MIN ? DIV_MIN : v;
  endfunction
endpackage

// File: rtl/clock_enable_divider_bank_channel.sv
// clock_enable_channel: one clock-enable generator with a runtime ratio applied at period boundaries
module clock_enable_channel
  import clock_enable_divider_bank_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_TOUCH_DIV)
) (
  input  logic             system_clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             tick,
  output logic             square,
  output logic             pending
);
  logic [DIV_W-1:0] count, active_div, pending_div;
  logic wrap, apply;
  assign wrap = count == active_div - DIV_W'(1);
  // a stopped channel has no period in flight, so a pending ratio can land at once
  assign apply = pending && (!enable || wrap);
  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      count <= '0;
      active_div <= RESET_DIV;
      pending_div <= RESET_DIV;
      pending <= 1'b0;
      tick <= 1'b0;
      square <= 1'b0;
    end else begin
      count <= enable && !wrap ? count + DIV_W'(1) : '0;
      tick <= enable && wrap;
      square <= enable && count < (active_div >> 1);
      if (apply) active_div <= pending_div;
      if (load) pending_div <= value;
      pending <= load || (pending && !apply);
    end
  end
endmodule

// File: rtl/clock_enable_divider_bank.sv
// clock_enable_divider_bank: bank of independent clock-enable channels sharing one ratio load port
module clock_enable_divider_bank
  import clock_enable_divider_bank_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 8,
  parameter int DEFAULT_DIV = DEFAULT_TOUCH_DIV,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              system_clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              div_load,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_value,
  output logic              div_ack,
  output logic [NUM_CH-1:0] div_pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square
);
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(clamp_div(DEFAULT_DIV));
  logic [DIV_W-1:0] value_c;
  logic in_range;
  assign value_c = div_value < DIV_W'(DIV_MIN) ? DIV_W'(DIV_MIN) : div_value;
  assign in_range = int'(div_ch) < NUM_CH;
  always_ff @(posedge system_clock) div_ack <= reset_n && div_load && in_range;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_enable_channel #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) u_ch (
      .system_clock(system_clock),
      .reset_n(reset_n),
      .enable(ch_enable[i]),
      .load(div_load && div_ch == CH_W'(i)),
      .value(value_c),
      .tick(tick[i]),
      .square(square[i]),
      .pending(div_pending[i])
    );
  end
endmodule

// File: tb/tb_clock_enable_divider_bank.sv
// tb_clock_enable_divider_bank: directed and randomized checks against a cycle-level behavioural model
module tb_clock_enable_divider_bank;
  localparam int N = 3;
  localparam int W = 8;
  localparam int DEF = 32;
  logic clk = 0, rst_n = 0, load = 0, ack;
  logic [N-1:0] en = '0, pend, tick, sq;
  logic [1:0] ch = '0;
  logic [W-1:0] val = '0;
  int vectors = 0, checks = 0, miscompares = 0, n, hi;
  int m_pos[N], m_d[N], m_pd[N];
  bit m_pend[N], m_tick[N], m_sq[N], m_ack;
  always #5 clk = ~clk;
  clock_enable_divider_bank #(.NUM_CH(N), .DIV_W(W), .DEFAULT_DIV(DEF)) dut (
    .system_clock(clk), .reset_n(rst_n), .ch_enable(en), .div_load(load), .div_ch(ch),
    .div_value(val), .div_ack(ack), .div_pending(pend), .tick(tick), .square(sq)
  );
  function automatic int clampv(input int v);
    return v < 2 ? 2 : v;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: position within the period, ratio in force, and the ratio waiting for the next boundary
  task automatic model_edge();
    bit boundary;
    m_ack = rst_n && load && ch < N;
    for (int c = 0; c < N; c++) begin
      if (!rst_n) begin
        m_pos[c] = 0; m_d[c] = clampv(DEF); m_pend[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
        continue;
      end
      if (en[c]) begin
        m_tick[c] = m_pos[c] == m_d[c] - 1;
        m_sq[c] = m_pos[c] < m_d[c] / 2;
        m_pos[c] = m_tick[c] ? 0 : m_pos[c] + 1;
        boundary = m_tick[c];
      end else begin
        m_pos[c] = 0; m_tick[c] = 0; m_sq[c] = 0; boundary = 1;
      end
      if (boundary && m_pend[c]) begin
        m_d[c] = m_pd[c]; m_pend[c] = 0;
      end
      if (load && ch == c) begin
        m_pd[c] = clampv(val); m_pend[c] = 1;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    check("ack", ack, m_ack);
    for (int c = 0; c < N; c++) begin
      check($sformatf("tick%0d", c), tick[c], m_tick[c]);
      check($sformatf("square%0d", c), sq[c], m_sq[c]);
      check($sformatf("pending%0d", c), pend[c], m_pend[c]);
    end
  endtask
  task automatic wait_tick(input int c, output int cnt);
    cnt = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (tick[c]) begin
        cnt = k;
        break;
      end
    end
  endtask
  task automatic do_load(input int c, input int v);
    load = 1; ch = 2'(c); val = W'(v);
    step();
    load = 0;
  endtask
  initial begin
    repeat (2) step();
    check("rst_pending", pend, 0);
    check("rst_tick", tick, 0);
    rst_n = 1; en = '1;
    wait_tick(0, n); check("first_tick", n, 32);
    check("first_tick_ch1", tick[1], 1);
    hi = 0;
    for (int k = 0; k < 32; k++) begin step(); hi += sq[0]; end
    check("square_high_32", hi, 16);
    check("tick_gap_32", tick[0], 1);
    repeat (10) step();
    do_load(0, 5);
    check("load5_ack", ack, 1);
    check("load5_pending", pend[0], 1);
    wait_tick(0, n); check("old_period_finish", n, 21);
    check("pending_dropped", pend[0], 0);
    wait_tick(0, n); check("tick_gap_5", n, 5);
    hi = 0;
    for (int k = 0; k < 5; k++) begin step(); hi += sq[0]; end
    check("square_high_5", hi, 2);
    do_load(1, 0);
    do_load(2, 1);
    repeat (40) step();
    wait_tick(1, n);
    wait_tick(1, n); check("tick_gap_2", n, 2);
    check("square2_low", sq[1], 0);
    step(); check("square2_high", sq[1], 1);
    wait_tick(0, n);
    do_load(0, 7); check("ack_7", ack, 1);
    do_load(0, 9); check("ack_9", ack, 1);
    wait_tick(0, n); check("finish_at_5", n, 3);
    wait_tick(0, n); check("tick_gap_9", n, 9);
    repeat (4) step();
    en[0] = 0;
    repeat (3) step();
    check("disabled_tick", tick[0], 0);
    check("disabled_square", sq[0], 0);
    en[0] = 1;
    wait_tick(0, n); check("reenable_gap", n, 9);
    do_load(3, 4);
    check("bad_ch_ack", ack, 0);
    check("bad_ch_pending", pend, 0);
    do_load(0, 40);
    check("pending_before_rst", pend[0], 1);
    rst_n = 0;
    step();
    check("rst_mid_pending", pend, 0);
    check("rst_mid_tick", tick, 0);
    check("rst_mid_square", sq, 0);
    rst_n = 1;
    wait_tick(0, n); check("ratio_restored", n, 32);
    for (int k = 0; k < 4000; k++) begin
      rst_n = $urandom_range(0, 499) != 0;
      for (int c = 0; c < N; c++) if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
      load = $urandom_range(0, 3) == 0;
      ch = 2'($urandom_range(0, 3));
      val = W'($urandom_range(0, 7) == 0 ? $urandom_range(0, 60) : $urandom_range(0, 10));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
